// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq.sv
// gf180mcu_fd_sc_mcu9t5v0__rstseq: reset/set sequencer for a bank of async set/reset flops.
// Synchronized reset release with hold time, plus programmable-width active-low set pulses.
module gf180mcu_fd_sc_mcu9t5v0__rstseq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int LEN_W       = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             SET_REQ,
    input  logic [LEN_W-1:0] SET_LEN,
    output logic             RN_OUT,
    output logic             SETN_OUT,
    output logic             BUSY,
    input  logic             VDD,
    input  logic             VSS
);
    typedef enum logic [2:0] {RESET, HOLD, RUN, PULSE, GAP} state_t;

    localparam logic [3:0] HOLD_N = 4'(HOLD_CYCLES);

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync, sync_nx;
    logic [3:0]             hold_cnt, hold_nx;
    logic [LEN_W-1:0]       len_cnt, len_nx;
    logic                   unused_pwr;

    assign unused_pwr = VDD ^ VSS;

    always_comb begin
        state_nx = state;
        sync_nx  = sync;
        hold_nx  = hold_cnt;
        len_nx   = len_cnt;
        case (state)
            RESET: begin
                sync_nx = {sync[SYNC_STAGES-2:0], 1'b1};
                if (sync_nx[SYNC_STAGES-1]) state_nx = HOLD;
            end
            HOLD: begin
                hold_nx = hold_cnt + 4'd1;
                if (hold_nx == HOLD_N) state_nx = RUN;
            end
            RUN: begin
                if (SET_REQ) begin
                    state_nx = PULSE;
                    len_nx   = (SET_LEN == '0) ? LEN_W'(1) : SET_LEN;
                end
            end
            PULSE: begin
                len_nx = len_cnt - LEN_W'(1);
                if (len_nx == '0) state_nx = GAP;
            end
            GAP:     state_nx = RUN;
            default: state_nx = RESET;
        endcase
    end

    // Outputs are registered from the next state so every pin comes straight off a flop.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= RESET;
            sync     <= '0;
            hold_cnt <= '0;
            len_cnt  <= '0;
            RN_OUT   <= 1'b0;
            SETN_OUT <= 1'b1;
            BUSY     <= 1'b1;
        end else begin
            state    <= state_nx;
            sync     <= sync_nx;
            hold_cnt <= hold_nx;
            len_cnt  <= len_nx;
            RN_OUT   <= state_nx inside {RUN, PULSE, GAP};
            SETN_OUT <= state_nx != PULSE;
            BUSY     <= state_nx != RUN;
        end
    end
endmodule
